control: RTL and testbench

CONTROL -- requirements
Module: control

---
 rtl/control.sv | 102 ++++++++++
 tb/tb_control.sv | 129 ++++++++++++
 2 files changed

// File: rtl/control.sv
// Main pipeline control: decodes the opcode and registers the control bits, with stall, flush and reset.
// Optional macro CONTROL_ILLEGAL_DET_EN adds the registered illegal_op_out flag.
module control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op_code_in,
    input  logic       stall_in,
    input  logic       flush_in,
    output logic [1:0] WB_out,
    output logic [1:0] MEM_out,
    output logic [3:0] EX_out,
    output logic       jump_out,
    output logic       branch_out
`ifdef CONTROL_ILLEGAL_DET_EN
    ,
    output logic       illegal_op_out
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [1:0] wb_dec;
    logic [1:0] mem_dec;
    logic [3:0] ex_dec;
    logic       jump_dec;
    logic       branch_dec;
    logic       illegal_dec;

    // Unknown opcodes decode to a bubble so they never write a register or memory.
    always_comb begin
        wb_dec      = 2'b00;
        mem_dec     = 2'b00;
        ex_dec      = 4'b0000;
        jump_dec    = 1'b0;
        branch_dec  = 1'b0;
        illegal_dec = 1'b0;
        case (op_code_in)
            OP_RTYPE: begin
                wb_dec = 2'b10;
                ex_dec = 4'b1100;
            end
            OP_J: begin
                ex_dec   = 4'b0010;
                jump_dec = 1'b1;
            end
            OP_BEQ: begin
                ex_dec     = 4'b0010;
                branch_dec = 1'b1;
            end
            OP_ADDI: begin
                wb_dec = 2'b10;
                ex_dec = 4'b0001;
            end
            OP_LW: begin
                wb_dec  = 2'b11;
                mem_dec = 2'b10;
                ex_dec  = 4'b0001;
            end
            OP_SW: begin
                mem_dec = 2'b01;
                ex_dec  = 4'b0001;
            end
            default: illegal_dec = 1'b1;
        endcase
    end

    // Priority: reset, then flush (even during a stall), then stall hold, then load.
    always_ff @(posedge clk) begin
        if (rst || flush_in) begin
            WB_out     <= 2'b00;
            MEM_out    <= 2'b00;
            EX_out     <= 4'b0000;
            jump_out   <= 1'b0;
            branch_out <= 1'b0;
        end else if (!stall_in) begin
            WB_out     <= wb_dec;
            MEM_out    <= mem_dec;
            EX_out     <= ex_dec;
            jump_out   <= jump_dec;
            branch_out <= branch_dec;
        end
    end

`ifdef CONTROL_ILLEGAL_DET_EN
    always_ff @(posedge clk) begin
        if (rst || flush_in) begin
            illegal_op_out <= 1'b0;
        end else if (!stall_in) begin
            illegal_op_out <= illegal_dec;
        end
    end
`else
    logic unused_illegal;
    assign unused_illegal = illegal_dec;
`endif

endmodule

// File: tb/tb_control.sv
// Directed bench for control: decode table, illegal opcodes, stall, flush and reset priority.
// Build with CONTROL_ILLEGAL_DET_EN to also check illegal_op_out.
module tb_control;

    logic       clk;
    logic       rst;
    logic [5:0] op_code_in;
    logic       stall_in;
    logic       flush_in;
    logic [1:0] WB_out;
    logic [1:0] MEM_out;
    logic [3:0] EX_out;
    logic       jump_out;
    logic       branch_out;
`ifdef CONTROL_ILLEGAL_DET_EN
    logic       illegal_op_out;
`endif

    int vectors;
    int miscompares;

    // Expected control words {WB, MEM, EX, jump, branch}
    localparam logic [9:0] E_NOP  = 10'b00_00_0000_0_0;
    localparam logic [9:0] E_R    = 10'b10_00_1100_0_0;
    localparam logic [9:0] E_J    = 10'b00_00_0010_1_0;
    localparam logic [9:0] E_BEQ  = 10'b00_00_0010_0_1;
    localparam logic [9:0] E_ADDI = 10'b10_00_0001_0_0;
    localparam logic [9:0] E_LW   = 10'b11_10_0001_0_0;
    localparam logic [9:0] E_SW   = 10'b00_01_0001_0_0;

    control dut (
        .clk        (clk),
        .rst        (rst),
        .op_code_in (op_code_in),
        .stall_in   (stall_in),
        .flush_in   (flush_in),
        .WB_out     (WB_out),
        .MEM_out    (MEM_out),
        .EX_out     (EX_out),
        .jump_out   (jump_out),
        .branch_out (branch_out)
`ifdef CONTROL_ILLEGAL_DET_EN
        ,
        .illegal_op_out (illegal_op_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [5:0] op, input logic s, input logic f, input logic r);
        op_code_in = op;
        stall_in   = s;
        flush_in   = f;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [9:0] exp, input logic ill);
        logic [10:0] obs;
        logic [10:0] want;
`ifdef CONTROL_ILLEGAL_DET_EN
        obs  = {illegal_op_out, WB_out, MEM_out, EX_out, jump_out, branch_out};
        want = {ill, exp};
`else
        obs  = {1'b0, WB_out, MEM_out, EX_out, jump_out, branch_out};
        want = {1'b0, exp};
`endif
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s observed=%b required=%b", tag, obs, want);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        stall_in    = 1'b0;
        flush_in    = 1'b0;
        op_code_in  = 6'b100011;

        // reset wins over stall and flush
        step(6'b100011, 1'b1, 1'b1, 1'b1);
        step(6'b100011, 1'b1, 1'b0, 1'b1);
        check("reset", E_NOP, 1'b0);

        step(6'b000000, 1'b0, 1'b0, 1'b0); check("rtype", E_R, 1'b0);
        step(6'b000010, 1'b0, 1'b0, 1'b0); check("j", E_J, 1'b0);
        step(6'b000100, 1'b0, 1'b0, 1'b0); check("beq", E_BEQ, 1'b0);
        step(6'b001000, 1'b0, 1'b0, 1'b0); check("addi", E_ADDI, 1'b0);
        step(6'b100011, 1'b0, 1'b0, 1'b0); check("lw", E_LW, 1'b0);
        step(6'b101011, 1'b0, 1'b0, 1'b0); check("sw", E_SW, 1'b0);

        step(6'b111111, 1'b0, 1'b0, 1'b0); check("illegal_3f", E_NOP, 1'b1);
        step(6'b001000, 1'b0, 1'b0, 1'b0); check("legal_after_illegal", E_ADDI, 1'b0);
        step(6'b000001, 1'b0, 1'b0, 1'b0); check("illegal_01", E_NOP, 1'b1);
        step(6'b100010, 1'b0, 1'b0, 1'b0); check("illegal_22", E_NOP, 1'b1);

        // stall holds lw while sw is presented
        step(6'b100011, 1'b0, 1'b0, 1'b0); check("lw_load", E_LW, 1'b0);
        step(6'b101011, 1'b1, 1'b0, 1'b0); check("stall_1", E_LW, 1'b0);
        step(6'b101011, 1'b1, 1'b0, 1'b0); check("stall_2", E_LW, 1'b0);
        step(6'b111111, 1'b1, 1'b0, 1'b0); check("stall_3", E_LW, 1'b0);
        step(6'b101011, 1'b0, 1'b0, 1'b0); check("stall_release", E_SW, 1'b0);

        // stall also holds the illegal flag
        step(6'b110000, 1'b0, 1'b0, 1'b0); check("illegal_30", E_NOP, 1'b1);
        step(6'b000000, 1'b1, 1'b0, 1'b0); check("stall_illegal", E_NOP, 1'b1);

        // flush beats stall
        step(6'b000000, 1'b0, 1'b0, 1'b0); check("rtype_load", E_R, 1'b0);
        step(6'b000000, 1'b1, 1'b1, 1'b0); check("flush_stall", E_NOP, 1'b0);
        step(6'b000100, 1'b1, 1'b0, 1'b0); check("stall_after_flush", E_NOP, 1'b0);
        step(6'b111111, 1'b0, 1'b0, 1'b0); check("illegal_before_flush", E_NOP, 1'b1);
        step(6'b100011, 1'b0, 1'b1, 1'b0); check("flush_clears", E_NOP, 1'b0);

        // mid-stream reset then resume with j
        step(6'b000100, 1'b0, 1'b0, 1'b0); check("beq_load", E_BEQ, 1'b0);
        step(6'b000100, 1'b1, 1'b0, 1'b1); check("reset_mid", E_NOP, 1'b0);
        step(6'b000010, 1'b0, 1'b0, 1'b0); check("j_after_reset", E_J, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
